issue_window_ctrl: RTL and testbench
====================================

Name: issue_window_ctrl

Overview:
Collapsing in-order issue window controller for the 4-wide issue stage. Holds up to DEPTH dispatched instructions in age order, with slot 0 the oldest. Presents the four oldest slots to the dependency checkers and takes back their per-slot issue grants. On each clock edge it retires the granted slots, compacts the remaining entries downward, appends new dispatches at the tail, and registers the issued instructions toward the execution units.

Parameters:
DEPTH, 16, number of window slots; must be at least 4.
W, 32, instruction payload width in bits.
STALL_LIMIT, 63, consecutive cycles slot 0 may sit valid and unissued before stall_alarm asserts.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
flush  in  1  synchronous flush; discards all window contents.
disp_valid  in  2  dispatch lane valids; lane 0 is older than lane 1.
disp_data  in  2*W  dispatch payloads; lane n occupies bits [n*W +: W].
disp_ready  out  1  window can accept two dispatches this cycle.
cand_valid  out  4  combinational; valid bits of slots 0..3.
cand_data  out  4*W  combinational; payloads of slots 0..3.
issue_ok  in  4  checker grants for slots 0..3, sampled in the same cycle as cand_*.
iss_valid  out  4  registered; slot k was issued on the previous edge.
iss_data  out  4*W  registered; payloads of the issued slots.
count  out  $clog2(DEPTH+1)  registered occupancy.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
stall_alarm  out  1  registered; sticky until the next issue from slot 0, a flush, or reset.

Behaviour:
- Reset, applied asynchronously:
  - all slot valids 0, count 0, iss_valid 0, iss_data 0, stall counter 0, stall_alarm 0;
  - resulting outputs: empty 1, full 0, disp_ready 1, cand_valid 0.
- Effective grant g[k] = issue_ok[k] & cand_valid[k]. A grant on an invalid slot is ignored.
- Compaction each edge, with n = popcount(g):
  - slot k < 4, not granted: moves to slot k − popcount(g[k-1:0]);
  - slot k < 4, granted: leaves the window;
  - slot k ≥ 4: moves down by n.
  - Relative age order is always preserved. A hole never remains below a valid entry.
- Issue output: on the same edge, iss_valid <= g and iss_data[k] <= slot k payload. Issue latency is 1 cycle from the cand_* presentation. A slot whose iss_valid bit is 0 keeps its previous iss_data.
- Dispatch:
  - disp_ready = (count <= DEPTH-2), computed from registered count only. Freed issue slots do not raise it in the same cycle.
  - A lane is accepted when disp_valid[n] & disp_ready.
  - Accepted lanes are written at the post-compaction tail (count − n) in lane order, packed. A lone lane 1 takes the first free slot.
  - When disp_ready is 0, lanes are dropped. The upstream stage holds its data until ready.
- count_next = count − n + accepted. Range 0..DEPTH is guaranteed by the disp_ready rule.
- Simultaneous events:
  - issue and dispatch in one cycle: compaction happens first, then append.
  - dispatch into an empty window: the entry is visible on cand_* the next cycle and cannot issue in its dispatch cycle.
- Flush:
  - takes priority over dispatch and issue; all slots invalid and count 0 on the next edge;
  - iss_valid <= 0 on that edge, so grants in the flush cycle are discarded;
  - stall counter and stall_alarm clear.
- Stall monitor, a saturating counter:
  - increments when cand_valid[0] & ~g[0];
  - clears when g[0] or slot 0 is empty;
  - stall_alarm sets on the edge where the counter reaches STALL_LIMIT and stays set until the counter clears.
- Reset asserted mid-operation discards all contents immediately. No partial issue is emitted after reset releases.

Test Plan:
- Reset, then dispatch A,B on both lanes, then C,D. Required: count 4, cand_valid 1111, cand_data A,B,C,D, disp_ready 1, empty 0.
- With A..F held (count 6), issue_ok 0101. Required next cycle:
  - iss_valid 0101, iss_data slot0 = A, slot2 = C;
  - window B,D,E,F; count 4.
- Fill to count 15. Required: disp_ready 0 and dispatches ignored. Then issue_ok 1111 with two dispatches presented. Required: dispatches still dropped that cycle; count 11; disp_ready 1 next cycle.
- Count 3 (X,Y,Z), issue_ok 1011 plus dispatch P,Q in the same cycle. Required: iss_valid 0011 (slot 3 grant on an invalid slot ignored); window Z,P,Q; count 3.
- Count 8, flush together with issue_ok 1111 and disp_valid 11. Required next cycle: count 0, empty 1, iss_valid 0000, cand_valid 0000.
- STALL_LIMIT 3, slot 0 valid, issue_ok 0000 held. Required:
  - stall_alarm 1 after the 3rd edge and held;
  - issue_ok 0001 clears stall_alarm on the next edge;
  - async rst pulse mid-sequence clears every output within the same cycle.

Source files
------------

// File: rtl/issue_window_if.sv
// Handshake bundle between dispatch, the dependency checkers, the issue window
// and the execution-side issue register.
interface issue_window_if #(
  parameter int W = 32
);
  logic [1:0]     disp_valid;
  logic [2*W-1:0] disp_data;
  logic           disp_ready;
  logic [3:0]     cand_valid;
  logic [4*W-1:0] cand_data;
  logic [3:0]     issue_ok;
  logic [3:0]     iss_valid;
  logic [4*W-1:0] iss_data;

  modport master (
    output disp_valid, disp_data, issue_ok,
    input  disp_ready, cand_valid, cand_data, iss_valid, iss_data
  );

  modport slave (
    input  disp_valid, disp_data, issue_ok,
    output disp_ready, cand_valid, cand_data, iss_valid, iss_data
  );
endinterface

// File: rtl/issue_window_ctrl.sv
// Collapsing in-order issue window: slot 0 is oldest, the four oldest slots are
// offered for issue, granted slots retire and survivors compact toward slot 0.
module issue_window_ctrl #(
  parameter int DEPTH       = 16,
  parameter int W           = 32,
  parameter int STALL_LIMIT = 63,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  issue_window_if.slave bus,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          stall_alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [W-1:0]  slot_reg  [DEPTH];
  logic [W-1:0]  slot_next [DEPTH];
  logic [3:0]    grant;
  logic [2:0]    n_issue;
  logic          disp_ready;
  logic          acc0;
  logic          acc1;
  logic [CW-1:0] tail;
  logic [3:0]    iss_valid_reg;
  logic [SW-1:0] stall_reg;
  logic [SW-1:0] stall_next;
  logic          alarm_reg;
  logic          stall_clear;

  // Occupancy is always packed from slot 0, so validity is just k < count.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign bus.cand_valid[gi]          = (count_reg > CW'(gi));
    assign bus.cand_data[gi*W +: W]    = slot_reg[gi];
  end

  assign grant          = bus.issue_ok & bus.cand_valid;
  assign disp_ready     = (count_reg <= CW'(DEPTH - 2));
  assign bus.disp_ready = disp_ready;
  assign acc0           = bus.disp_valid[0] & disp_ready;
  assign acc1           = bus.disp_valid[1] & disp_ready;

  always_comb begin
    logic [2:0] shift;
    shift = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_next[k] = slot_reg[k];
    end
    // Candidate slots fall by the number of grants strictly below them.
    for (int k = 0; k < 4; k++) begin
      if (bus.cand_valid[k] && !grant[k]) begin
        slot_next[AW'(k) - AW'(shift)] = slot_reg[k];
      end
      shift = shift + {2'b00, grant[k]};
    end
    n_issue = shift;
    for (int k = 4; k < DEPTH; k++) begin
      if (CW'(k) < count_reg) begin
        slot_next[AW'(k) - AW'(n_issue)] = slot_reg[k];
      end
    end
    // Append after compaction; a lone lane 1 lands at the tail itself.
    tail = count_reg - CW'(n_issue);
    if (acc0) begin
      slot_next[AW'(tail)] = bus.disp_data[0 +: W];
    end
    if (acc1) begin
      slot_next[AW'(tail + CW'(acc0))] = bus.disp_data[W +: W];
    end
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = tail + CW'(acc0) + CW'(acc1);
    end
  end

  assign stall_clear = flush | grant[0] | ~bus.cand_valid[0];
  assign stall_next  = stall_clear ? '0 :
                       (stall_reg == SW'(STALL_LIMIT)) ? stall_reg : stall_reg + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= '0;
      iss_valid_reg <= '0;
      stall_reg     <= '0;
      alarm_reg     <= 1'b0;
    end else begin
      count_reg     <= count_next;
      iss_valid_reg <= flush ? 4'b0000 : grant;
      stall_reg     <= stall_next;
      alarm_reg     <= stall_clear ? 1'b0 : (alarm_reg | (stall_next == SW'(STALL_LIMIT)));
    end
  end

  // Payload storage carries no reset: contents beyond count are never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_reg[k] <= slot_next[k];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_iss
    logic [W-1:0] data_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_reg <= '0;
      end else if (!flush && grant[gi]) begin
        data_reg <= slot_reg[gi];
      end
    end
    assign bus.iss_data[gi*W +: W] = data_reg;
  end

  assign bus.iss_valid = iss_valid_reg;
  assign count         = count_reg;
  assign empty         = (count_reg == '0);
  assign full          = (count_reg == CW'(DEPTH));
  assign stall_alarm   = alarm_reg;

endmodule

// File: tb/tb_issue_window_ctrl.sv
// Scoreboard bench for issue_window_ctrl: a queue model of the window predicts
// each issue transaction, which is compared one edge later.
module tb_issue_window_ctrl;
  localparam int DEPTH = 16;
  localparam int W     = 32;
  localparam int STALL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       stall_alarm;

  issue_window_if #(.W(W)) bus ();

  issue_window_ctrl #(.DEPTH(DEPTH), .W(W), .STALL_LIMIT(STALL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
    .count(count), .empty(empty), .full(full), .stall_alarm(stall_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     v;
    logic [4*W-1:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [W-1:0] win[$];
  logic [W-1:0] exp_d[4];
  int         stall_m;
  logic       alarm_m;
  int         n_tests = 0;
  int         n_fail  = 0;

  localparam logic [W-1:0] A = 32'hA000_000A, B = 32'hB000_000B, C = 32'hC000_000C;
  localparam logic [W-1:0] D = 32'hD000_000D, E = 32'hE000_000E, F = 32'hF000_000F;

  task automatic model_reset();
    win.delete();
    sb.delete();
    for (int k = 0; k < 4; k++) exp_d[k] = '0;
    stall_m = 0;
    alarm_m = 1'b0;
  endtask

  // Drives one cycle, advances the model and queues the expected issue result.
  task automatic cycle(input logic fl, input logic [1:0] dv, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic [3:0] iok);
    exp_t         e;
    logic [3:0]   g;
    logic         rdy;
    int           sz;
    logic [W-1:0] nw[$];
    @(negedge clk);
    flush          = fl;
    bus.disp_valid = dv;
    bus.disp_data  = {d1, d0};
    bus.issue_ok   = iok;
    sz  = win.size();
    rdy = (sz <= DEPTH - 2);
    g   = '0;
    for (int k = 0; k < 4; k++) if (iok[k] && k < sz) g[k] = 1'b1;
    if (fl) begin
      e.v = 4'b0000;
      win.delete();
      stall_m = 0;
      alarm_m = 1'b0;
    end else begin
      e.v = g;
      for (int k = 0; k < 4; k++) if (g[k]) exp_d[k] = win[k];
      for (int k = 0; k < sz; k++) if (!(k < 4 && g[k])) nw.push_back(win[k]);
      if (rdy && dv[0]) nw.push_back(d0);
      if (rdy && dv[1]) nw.push_back(d1);
      win = nw;
      if (sz > 0 && !g[0]) begin
        if (stall_m < STALL) stall_m++;
        if (stall_m == STALL) alarm_m = 1'b1;
      end else begin
        stall_m = 0;
        alarm_m = 1'b0;
      end
    end
    e.d = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
    if (fl || iok != 4'b0000) sb.push_back(e);
    $display("[TB] cycle flush=%0b dv=%b iok=%b grant=%b model_count=%0d", fl, dv, iok, g, win.size());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.disp_valid = '0; bus.disp_data = '0; bus.issue_ok = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || bus.disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status count=%0d empty=%b full=%b ready=%b want 0 1 0 1", count, empty, full, bus.disp_ready);
    end
    n_tests++;
    if (bus.cand_valid !== 4'b0 || bus.iss_valid !== 4'b0 || bus.iss_data !== '0 || stall_alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs cand_valid=%b iss_valid=%b iss_data=%h alarm=%b want zeros",
               bus.cand_valid, bus.iss_valid, bus.iss_data, stall_alarm);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dispatch();
    cycle(1'b0, 2'b11, A, B, 4'b0000);
    cycle(1'b0, 2'b11, C, D, 4'b0000);
    n_tests++;
    if (count !== 5'd4 || bus.cand_valid !== 4'b1111 || bus.disp_ready !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL dispatch_status count=%0d cand_valid=%b ready=%b empty=%b want 4 1111 1 0",
               count, bus.cand_valid, bus.disp_ready, empty);
    end
    n_tests++;
    if (bus.cand_data !== {D, C, B, A}) begin
      n_fail++;
      $display("FAIL dispatch_data got=%h want=%h", bus.cand_data, {D, C, B, A});
    end
  endtask

  task automatic test_partial_issue();
    exp_t e;
    cycle(1'b0, 2'b11, E, F, 4'b0000);
    cycle(1'b0, 2'b00, '0, '0, 4'b0101);
    e = sb.pop_front();
    n_tests++;
    if (bus.iss_valid !== e.v || bus.iss_valid !== 4'b0101 || bus.iss_data !== e.d ||
        bus.iss_data[31:0] !== A || bus.iss_data[95:64] !== C) begin
      n_fail++;
      $display("FAIL partial_issue iss_valid=%b data=%h want %b %h", bus.iss_valid, bus.iss_data, e.v, e.d);
    end
    n_tests++;
    if (count !== 5'd4 || bus.cand_data !== {F, E, D, B}) begin
      n_fail++;
      $display("FAIL partial_window count=%0d data=%h want 4 %h", count, bus.cand_data, {F, E, D, B});
    end
  endtask

  task automatic test_full();
    exp_t e;
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'b11, 32'h100 + i, 32'h200 + i, 4'b0000);
    cycle(1'b0, 2'b01, 32'h300, 32'h301, 4'b0000);
    n_tests++;
    if (count !== 5'd15 || bus.disp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill15 count=%0d ready=%b want 15 0", count, bus.disp_ready);
    end
    cycle(1'b0, 2'b11, 32'h400, 32'h401, 4'b0000);
    n_tests++;
    if (count !== 5'd15) begin
      n_fail++;
      $display("FAIL drop_when_not_ready count=%0d want 15", count);
    end
    cycle(1'b0, 2'b11, 32'h500, 32'h501, 4'b1111);
    e = sb.pop_front();
    n_tests++;
    if (bus.iss_valid !== 4'b1111 || bus.iss_data !== e.d || count !== 5'd11 || bus.disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_from_15 iss_valid=%b data=%h count=%0d ready=%b want 1111 %h 11 1",
               bus.iss_valid, bus.iss_data, count, bus.disp_ready, e.d);
    end
    cycle(1'b0, 2'b10, 32'h600, 32'h601, 4'b0000);
    cycle(1'b0, 2'b11, 32'h700, 32'h701, 4'b0000);
    cycle(1'b0, 2'b11, 32'h800, 32'h801, 4'b0000);
    n_tests++;
    if (count !== 5'd16 || full !== 1'b1 || bus.disp_ready !== 1'b0 || bus.cand_data[127:96] !== win[3]) begin
      n_fail++;
      $display("FAIL fill16 count=%0d full=%b ready=%b slot3=%h want 16 1 0 %h",
               count, full, bus.disp_ready, bus.cand_data[127:96], win[3]);
    end
  endtask

  task automatic test_collapse_dispatch();
    exp_t e;
    logic [W-1:0] x, y, z, p, q;
    x = 32'h0000_0A01; y = 32'h0000_0A02; z = 32'h0000_0A03; p = 32'h0000_0B01; q = 32'h0000_0B02;
    cycle(1'b1, 2'b00, '0, '0, 4'b0000);
    e = sb.pop_front();
    n_tests++;
    if (bus.iss_valid !== e.v || count !== 5'd0) begin
      n_fail++;
      $display("FAIL pre_flush iss_valid=%b count=%0d want 0000 0", bus.iss_valid, count);
    end
    cycle(1'b0, 2'b11, x, y, 4'b0000);
    cycle(1'b0, 2'b10, 32'h0, z, 4'b0000);
    cycle(1'b0, 2'b11, p, q, 4'b1011);
    e = sb.pop_front();
    n_tests++;
    if (bus.iss_valid !== 4'b0011 || bus.iss_data !== e.d || bus.iss_data[31:0] !== x || bus.iss_data[63:32] !== y) begin
      n_fail++;
      $display("FAIL collapse_issue iss_valid=%b data=%h want 0011 %h", bus.iss_valid, bus.iss_data, e.d);
    end
    n_tests++;
    if (count !== 5'd3 || bus.cand_valid !== 4'b0111 || bus.cand_data[95:0] !== {q, p, z}) begin
      n_fail++;
      $display("FAIL collapse_window count=%0d cv=%b data=%h want 3 0111 %h",
               count, bus.cand_valid, bus.cand_data[95:0], {q, p, z});
    end
  endtask

  task automatic test_flush();
    exp_t e;
    cycle(1'b0, 2'b11, 32'h900, 32'h901, 4'b0000);
    cycle(1'b0, 2'b11, 32'h902, 32'h903, 4'b0000);
    cycle(1'b0, 2'b01, 32'h904, 32'h905, 4'b0000);
    n_tests++;
    if (count !== 5'd8) begin
      n_fail++;
      $display("FAIL flush_setup count=%0d want 8", count);
    end
    cycle(1'b1, 2'b11, 32'h906, 32'h907, 4'b1111);
    e = sb.pop_front();
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || bus.iss_valid !== e.v || bus.cand_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush count=%0d empty=%b iss_valid=%b cv=%b want 0 1 0000 0000",
               count, empty, bus.iss_valid, bus.cand_valid);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    cycle(1'b0, 2'b01, 32'h5000, 32'h0, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 2'b00, '0, '0, 4'b0000);
      n_tests++;
      if (stall_alarm !== alarm_m || stall_alarm !== (i >= STALL)) begin
        n_fail++;
        $display("FAIL stall_edge%0d alarm=%b want %b", i, stall_alarm, alarm_m);
      end
    end
    cycle(1'b0, 2'b00, '0, '0, 4'b0001);
    e = sb.pop_front();
    n_tests++;
    if (stall_alarm !== 1'b0 || bus.iss_valid !== e.v || bus.iss_data !== e.d) begin
      n_fail++;
      $display("FAIL stall_clear alarm=%b iss_valid=%b data=%h want 0 %b %h",
               stall_alarm, bus.iss_valid, bus.iss_data, e.v, e.d);
    end
    cycle(1'b0, 2'b11, 32'h6000, 32'h6001, 4'b0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, '0, '0, 4'b0000);
    n_tests++;
    if (stall_alarm !== 1'b1 || count !== 5'd2) begin
      n_fail++;
      $display("FAIL stall_rearm alarm=%b count=%0d want 1 2", stall_alarm, count);
    end
    cycle(1'b0, 2'b00, '0, '0, 4'b0001);
    void'(sb.pop_front());
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || bus.cand_valid !== 4'b0 || bus.iss_valid !== 4'b0 ||
        bus.iss_data !== '0 || stall_alarm !== 1'b0 || bus.disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset count=%0d empty=%b cv=%b iv=%b data=%h alarm=%b ready=%b",
               count, empty, bus.cand_valid, bus.iss_valid, bus.iss_data, stall_alarm, bus.disp_ready);
    end
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b0, 2'b00, '0, '0, 4'b1111);
    e = sb.pop_front();
    n_tests++;
    if (bus.iss_valid !== e.v || bus.iss_valid !== 4'b0000 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset_issue iss_valid=%b count=%0d want 0000 0", bus.iss_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t           e;
    logic [3:0]     exp_cv;
    logic [4*W-1:0] exp_cd;
    logic [4*W-1:0] mask;
    logic [3:0]     iok;
    for (int i = 0; i < 80; i++) begin
      iok = 4'($urandom_range(0, 15));
      cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, iok);
      n_tests++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (bus.iss_valid !== e.v || bus.iss_data !== e.d) begin
          n_fail++;
          $display("FAIL b2b_issue%0d iss_valid=%b data=%h want %b %h", i, bus.iss_valid, bus.iss_data, e.v, e.d);
        end
      end else if (bus.iss_valid !== 4'b0000) begin
        n_fail++;
        $display("FAIL b2b_idle%0d iss_valid=%b want 0000", i, bus.iss_valid);
      end
      exp_cv = '0; exp_cd = '0; mask = '0;
      for (int k = 0; k < 4; k++) begin
        if (k < win.size()) begin
          exp_cv[k] = 1'b1;
          exp_cd[k*W +: W] = win[k];
          mask[k*W +: W] = '1;
        end
      end
      n_tests++;
      if (count !== 5'(win.size()) || bus.cand_valid !== exp_cv || (bus.cand_data & mask) !== exp_cd ||
          bus.disp_ready !== (win.size() <= DEPTH - 2)) begin
        n_fail++;
        $display("FAIL b2b_window%0d count=%0d cv=%b data=%h want %0d %b %h",
                 i, count, bus.cand_valid, bus.cand_data & mask, win.size(), exp_cv, exp_cd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_partial_issue();
    test_full();
    test_collapse_dispatch();
    test_flush();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
